// File: rtl/glyph_row_fetch.sv
// Glyph row fetch: reads one glyph row from the character ROM chosen by the
// pointer's chip select and shifts it out one pixel per `shift`, MSB first.
module glyph_row_fetch #(
  parameter int WORD_W  = 32,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [9:0]        pointer_y,
  input  logic [1:0]        chip_select,
  input  logic [5:0]        row,
  output logic              rom_rd,
  output logic [1:0]        rom_sel,
  output logic [9:0]        rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic              busy,
  output logic              row_ready,
  output logic              pixel,
  input  logic              shift,
  output logic              range_err
);

  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
  localparam logic [1:0]       LAT_LAST = 2'(ROM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_READY
  } state_e;

  state_e            state_q, state_d;
  logic              rom_rd_q, rom_rd_d;
  logic [9:0]        rom_addr_q, rom_addr_d;
  logic [1:0]        rom_sel_q, rom_sel_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        lat_q, lat_d;
  logic              range_err_q, range_err_d;
  logic              busy_q, busy_d;
  logic              row_ready_q, row_ready_d;

  logic accept;
  logic req_err;
  logic [5:0] req_height;

  // Blank select (00) has no height; it can never be out of range.
  always_comb begin
    req_height = 6'd0;
    case (chip_select)
      2'b01:   req_height = 6'd60;
      2'b10:   req_height = 6'd20;
      2'b11:   req_height = 6'd20;
      default: req_height = 6'd0;
    endcase
  end

  assign req_err = (chip_select != 2'b00) && (row >= req_height);
  assign accept  = start && ((state_q == S_IDLE) || (state_q == S_READY));

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case
    // leaves a signal unassigned and infers a latch.
    state_d     = state_q;
    rom_rd_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_sel_d   = rom_sel_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    lat_d       = lat_q;
    range_err_d = range_err_q;
    busy_d      = 1'b0;
    row_ready_d = 1'b0;

    if (accept) begin
      // A new request always wins over a pending shift; the old row is dropped.
      range_err_d = req_err;
      if ((chip_select == 2'b00) || req_err) begin
        state_d     = S_READY;
        shreg_d     = '0;
        cnt_d       = '0;
        row_ready_d = 1'b1;
      end else begin
        state_d    = S_ISSUE;
        rom_rd_d   = 1'b1;
        rom_addr_d = pointer_y + 10'(row);
        rom_sel_d  = chip_select;
        busy_d     = 1'b1;
      end
    end else begin
      case (state_q)
        S_ISSUE: begin
          state_d = S_WAIT;
          lat_d   = 2'd0;
          busy_d  = 1'b1;
        end
        S_WAIT: begin
          if (lat_q == LAT_LAST) begin
            state_d     = S_READY;
            shreg_d     = rom_data;
            cnt_d       = '0;
            row_ready_d = 1'b1;
          end else begin
            lat_d  = lat_q + 2'd1;
            busy_d = 1'b1;
          end
        end
        S_READY: begin
          row_ready_d = 1'b1;
          if (shift) begin
            shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              state_d     = S_IDLE;
              row_ready_d = 1'b0;
              cnt_d       = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, matching the hardware.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rom_rd_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_sel_q   <= '0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      lat_q       <= '0;
      range_err_q <= 1'b0;
      busy_q      <= 1'b0;
      row_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_rd_q    <= rom_rd_d;
      rom_addr_q  <= rom_addr_d;
      rom_sel_q   <= rom_sel_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
      range_err_q <= range_err_d;
      busy_q      <= busy_d;
      row_ready_q <= row_ready_d;
    end
  end

  assign rom_rd    = rom_rd_q;
  assign rom_addr  = rom_addr_q;
  assign rom_sel   = rom_sel_q;
  assign busy      = busy_q;
  assign row_ready = row_ready_q;
  assign pixel     = shreg_q[WORD_W-1];
  assign range_err = range_err_q;

endmodule

// File: tb/tb_glyph_row_fetch.sv
// Directed bench for glyph_row_fetch: one instance at ROM_LAT=1, one at
// ROM_LAT=3, each fed by a ROM model that drives garbage outside its slot.
module tb_glyph_row_fetch;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- ROM_LAT = 1 instance ----------------
  logic        start, shift, rom_rd, busy, row_ready, pixel, range_err;
  logic [9:0]  pointer_y, rom_addr;
  logic [1:0]  chip_select, rom_sel;
  logic [5:0]  row;
  logic [31:0] rom_data, rom_word;
  logic        p1 = 1'b0;
  int          rd_cnt = 0;

  glyph_row_fetch #(.WORD_W(32), .ROM_LAT(1)) dut (
    .clk(clk), .reset(reset), .start(start), .pointer_y(pointer_y),
    .chip_select(chip_select), .row(row), .rom_rd(rom_rd), .rom_sel(rom_sel),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy),
    .row_ready(row_ready), .pixel(pixel), .shift(shift), .range_err(range_err)
  );

  always @(posedge clk) begin
    p1 <= rom_rd;
    if (rom_rd) rd_cnt <= rd_cnt + 1;
  end
  assign rom_data = p1 ? rom_word : 32'hDEAD_BEEF;

  // ---------------- ROM_LAT = 3 instance ----------------
  logic        start3, shift3, rom_rd3, busy3, row_ready3, pixel3, range_err3;
  logic [9:0]  pointer_y3, rom_addr3;
  logic [1:0]  chip_select3, rom_sel3;
  logic [5:0]  row3;
  logic [31:0] rom_data3, rom_word3;
  logic [2:0]  p3 = 3'b000;

  glyph_row_fetch #(.WORD_W(32), .ROM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .pointer_y(pointer_y3),
    .chip_select(chip_select3), .row(row3), .rom_rd(rom_rd3),
    .rom_sel(rom_sel3), .rom_addr(rom_addr3), .rom_data(rom_data3),
    .busy(busy3), .row_ready(row_ready3), .pixel(pixel3), .shift(shift3),
    .range_err(range_err3)
  );

  always @(posedge clk) p3 <= {p3[1:0], rom_rd3};
  assign rom_data3 = p3[2] ? rom_word3 : 32'hDEAD_BEEF;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_n(input int n, output logic [31:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      got   = {got[30:0], pixel};
      shift = 1'b1;
      step();
      shift = 1'b0;
    end
  endtask

  task automatic shift3_n(input int n, output logic [31:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      got    = {got[30:0], pixel3};
      shift3 = 1'b1;
      step();
      shift3 = 1'b0;
    end
  endtask

  task automatic req(input logic [9:0] py, input logic [5:0] r,
                     input logic [1:0] cs);
    pointer_y = py; row = r; chip_select = cs; start = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int rd0;

    reset = 1'b1;
    start = 0; shift = 0; pointer_y = 0; chip_select = 0; row = 0; rom_word = 0;
    start3 = 0; shift3 = 0; pointer_y3 = 0; chip_select3 = 0; row3 = 0;
    rom_word3 = 0;
    step(); step();
    reset = 1'b0;

    // Reset state
    check("rst_outs", {rom_rd, busy, row_ready, pixel, range_err}, 0);
    check("rst_addr_sel", {rom_addr, rom_sel}, 0);
    check("rst_outs3", {rom_rd3, busy3, row_ready3, pixel3, range_err3}, 0);

    // Digits ROM fetch; a stray shift during ISSUE must be ignored
    rom_word = 32'hA000_0001;
    req(10'd120, 6'd5, 2'b01);
    step();
    start = 1'b0;
    shift = 1'b1;
    check("t1_rom_rd", rom_rd, 1);
    check("t1_addr", rom_addr, 125);
    check("t1_sel", rom_sel, 1);
    check("t1_busy_ready", {busy, row_ready}, 2'b10);
    step();
    shift = 1'b0;
    check("t1_wait", {rom_rd, busy, row_ready}, 3'b010);
    step();
    check("t1_ready", {busy, row_ready, pixel}, 3'b011);
    shift_n(32, got);
    check("t1_pixels", got, 32'hA000_0001);
    check("t1_idle", {busy, row_ready}, 0);

    // Blank select: no ROM read, zero pixels, address held
    rd0 = rd_cnt;
    req(10'd7, 6'd2, 2'b00);
    step();
    start = 1'b0;
    check("t2_ready", {busy, row_ready, range_err}, 3'b010);
    check("t2_addr_hold", rom_addr, 125);
    shift_n(32, got);
    check("t2_pixels", got, 0);
    check("t2_no_rd", rd_cnt, rd0);
    check("t2_idle", row_ready, 0);

    // AM/PM row beyond height, then a legal row clears the error
    req(10'd0, 6'd25, 2'b10);
    step();
    start = 1'b0;
    check("t3_err", {range_err, row_ready, rom_rd}, 3'b110);
    shift_n(32, got);
    check("t3_pixels", got, 0);
    check("t3_err_held", {range_err, row_ready}, 2'b10);
    check("t3_no_rd", rd_cnt, rd0);
    rom_word = 32'h1234_5678;
    req(10'd0, 6'd3, 2'b10);
    step();
    start = 1'b0;
    check("t3_err_clr", range_err, 0);
    check("t3_rd_addr", {rom_rd, rom_addr}, {1'b1, 10'd3});
    check("t3_sel", rom_sel, 2);
    step(); step();
    shift_n(32, got);
    check("t3_pixels2", got, 32'h1234_5678);

    // Height boundaries: row 60 on digits and 20 on colour tag are errors
    req(10'd0, 6'd60, 2'b01);
    step();
    check("bnd_60_err", {range_err, row_ready}, 2'b11);
    req(10'd0, 6'd20, 2'b11);
    step();
    check("bnd_20_err", range_err, 1);
    req(10'd100, 6'd19, 2'b11);
    step();
    start = 1'b0;
    check("bnd_19_ok", {range_err, rom_rd}, 2'b01);
    check("bnd_19_addr", rom_addr, 119);
    step(); step();

    // Start held through ISSUE and WAIT yields exactly one read
    rd0 = rd_cnt;
    rom_word = 32'hF0F0_0F0F;
    req(10'd200, 6'd10, 2'b01);
    step();
    check("t4_rd_addr", {rom_rd, rom_addr}, {1'b1, 10'd210});
    step();
    check("t4_wait_hold", {rom_rd, busy}, 2'b01);
    step();
    start = 1'b0;
    check("t4_ready", row_ready, 1);
    check("t4_one_rd", rd_cnt, rd0 + 1);
    shift_n(10, got);
    check("t4_first10", got, 32'h3C3);

    // Start together with shift after 10 pixels: new fetch wins
    rom_word = 32'h8000_0000;
    req(10'd300, 6'd1, 2'b11);
    shift = 1'b1;
    step();
    start = 1'b0;
    shift = 1'b0;
    check("t4_refetch", {rom_rd, row_ready, busy}, 3'b101);
    check("t4_refetch_as", {rom_addr, rom_sel}, {10'd301, 2'd3});
    step(); step();
    check("t4_new_row", {row_ready, pixel}, 2'b11);

    // Back-to-back: start on the final shift keeps row_ready up
    shift_n(31, got);
    check("b2b_31", {row_ready, got}, {1'b1, 32'h4000_0000});
    req(10'd0, 6'd0, 2'b00);
    shift = 1'b1;
    step();
    start = 1'b0;
    shift = 1'b0;
    check("b2b_no_bubble", {row_ready, pixel, busy}, 3'b100);
    shift_n(32, got);
    check("b2b_done", {row_ready, got}, 0);

    // ROM_LAT=3: top legal address, capture exactly three cycles after rom_rd
    rom_word3 = 32'hC3C3_3C3C;
    pointer_y3 = 10'd540; row3 = 6'd59; chip_select3 = 2'b01; start3 = 1'b1;
    step();
    start3 = 1'b0;
    check("l3_rd_addr", {rom_rd3, rom_addr3}, {1'b1, 10'd599});
    step(); step(); step();
    check("l3_not_yet", {busy3, row_ready3}, 2'b10);
    step();
    check("l3_ready", {busy3, row_ready3, range_err3}, 3'b010);
    shift3_n(32, got);
    check("l3_pixels", got, 32'hC3C3_3C3C);

    // Reset during WAIT; late ROM data must not raise row_ready
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    step();
    check("rw_in_wait", busy3, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rw_outs", {rom_rd3, busy3, row_ready3, pixel3, range_err3}, 0);
    check("rw_addr_sel", {rom_addr3, rom_sel3}, 0);
    step(); step(); step();
    check("rw_late_data", {busy3, row_ready3, pixel3}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
